// File: rtl/mem_port_req.sv
// Per-processor burst requester for the shared scratchpad: turns one read/write burst
// command into per-beat arbiter requests and streams read data back with fixed latency.
module mem_port_req #(
  parameter int BUS_SIZE = 128,
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // burst command
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [LEN_W-1:0]    i_cmd_len,
  // write data stream from the processor
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [BUS_SIZE-1:0] i_wdata,
  // read data stream to the processor
  output logic                o_rdata_valid,
  output logic [BUS_SIZE-1:0] o_rdata,
  output logic                o_done,
  output logic                o_busy,
  // shared memory read arbiter
  output logic                o_req_rd,
  input  logic                i_grant_rd,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [BUS_SIZE-1:0] i_rd_data,
  // shared memory write arbiter
  output logic                o_req_wr,
  input  logic                i_grant_wr,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [BUS_SIZE-1:0] o_wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_DRAIN,
    WR_REQ
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    cnt_q;      // granted beats still to go, minus one
  logic [LEN_W:0]      wrem_q;     // write beats still to accept from the processor
  logic [BUS_SIZE-1:0] wbuf_q;
  logic                wfull_q;
  logic                wdone_q;    // last write beat granted last cycle
  logic [RD_LAT-1:0]   vld_sr_q, vld_nxt;
  logic [RD_LAT-1:0]   last_sr_q, last_nxt;

  logic cmd_fire, rd_beat, wr_beat, wr_accept, cnt_zero, rd_done;

  assign cnt_zero  = (cnt_q == '0);
  assign cmd_fire  = i_cmd_valid & o_cmd_ready;
  assign rd_beat   = o_req_rd & i_grant_rd;
  assign wr_beat   = o_req_wr & i_grant_wr;
  assign wr_accept = i_wdata_valid & o_wdata_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    o_cmd_ready   = 1'b0;
    o_busy        = 1'b1;
    o_req_rd      = 1'b0;
    o_req_wr      = 1'b0;
    o_rd_addr     = '0;
    o_wr_addr     = '0;
    o_wr_data     = '0;
    o_wdata_ready = 1'b0;
    rd_done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_busy      = 1'b0;
        o_cmd_ready = ~i_rst;
        if (cmd_fire) state_d = i_cmd_wr ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        o_req_rd  = 1'b1;
        o_rd_addr = addr_q;
        if (i_grant_rd && cnt_zero) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        // The last-beat marker travels alongside the valid bit of the final beat.
        if (last_sr_q[RD_LAT-1]) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        o_req_wr      = wfull_q;
        o_wr_addr     = addr_q;
        o_wr_data     = wbuf_q;
        o_wdata_ready = (wrem_q != '0) && (!wfull_q || i_grant_wr);
        if (wdone_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign vld_nxt  = rd_beat;
      assign last_nxt = rd_beat & cnt_zero;
    end else begin : g_latn
      assign vld_nxt  = {vld_sr_q[RD_LAT-2:0], rd_beat};
      assign last_nxt = {last_sr_q[RD_LAT-2:0], rd_beat & cnt_zero};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      wrem_q    <= '0;
      wfull_q   <= 1'b0;
      wdone_q   <= 1'b0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      vld_sr_q  <= vld_nxt;
      last_sr_q <= last_nxt;
      wdone_q   <= wr_beat & cnt_zero;

      if (cmd_fire) begin
        addr_q <= i_cmd_addr;
        cnt_q  <= i_cmd_len;
        wrem_q <= i_cmd_wr ? ({1'b0, i_cmd_len} + (LEN_W+1)'(1)) : '0;
      end else begin
        if (rd_beat || wr_beat) begin
          addr_q <= addr_q + ADDR_W'(1);
          if (!cnt_zero) cnt_q <= cnt_q - LEN_W'(1);
        end
        if (wr_accept) wrem_q <= wrem_q - (LEN_W+1)'(1);
      end

      // A granted beat and a fresh accept in the same cycle keep the buffer full.
      if (wr_accept)    wfull_q <= 1'b1;
      else if (wr_beat) wfull_q <= 1'b0;
    end
  end

  // NOTE: the data buffer has no reset; wfull_q alone decides whether its contents mean anything.
  always_ff @(posedge i_clk) begin
    if (wr_accept) wbuf_q <= i_wdata;
  end

  assign o_rdata_valid = vld_sr_q[RD_LAT-1];
  assign o_rdata       = o_rdata_valid ? i_rd_data : '0;
  assign o_done        = rd_done | wdone_q;

endmodule
